multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Parametrised multi-cycle control sequencer for the RV32I core; successor to the single-cycle `controller`. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over a valid/ready memory port with arbitrary wait states. Drives datapath write enables and mux selects, and traps on illegal opcodes or memory timeout. Sits inside `cpu` between the shared instruction/data memory port and `datapath`.

## Interface
- `MEM_TIMEOUT`, 16: max wait cycles per memory request before bus error; 0 disables the timeout.
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  32  IR contents from datapath.
- `branch_taken`  in  1  datapath comparator result, valid in EXEC.
- `mem_ready`  in  1  memory accepts/completes the request this cycle.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  store (valid only with `mem_req`).
- `mem_addr_sel`  out  1  0=PC, 1=ALU result.
- `ir_we`  out  1  latch `instr` from memory read data.
- `pc_we`  out  1  PC update.
- `pc_sel`  out  2  `PC_PLUS4`, `PC_BRANCH`, `PC_JALR`.
- `rf_we`  out  1  register file write.
- `wb_sel`  out  2  `WB_ALU`, `WB_MEM`, `WB_PC4`.
- `alu_op`  out  2  `ALU_ADD`, `ALU_FUNCT`, `ALU_CMP`.
- `illegal`, `bus_err`  out  1 each  sticky trap causes.
- `halted`  out  1  in TRAP.
- `retired`  out  CNT_W  instructions retired, wraps to 0.

## Operation
- Reset (async): state=FETCH; all outputs 0; counter 0; `illegal`/`bus_err`/`halted` 0.
- FETCH: `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0; on `mem_ready`: `ir_we`=1 -> DECODE.
- DECODE (1 cycle): dispatch on `instr[6:0]`: LOAD, STORE, OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH -> EXEC; anything else -> TRAP, `illegal`=1.
- EXEC (1 cycle): `alu_op`=ALU_ADD for LOAD/STORE/AUIPC/JAL/JALR, ALU_FUNCT for OP/OP-IMM/LUI, ALU_CMP for BRANCH. LOAD/STORE -> MEM; BRANCH: `pc_we`=1, `pc_sel`=`branch_taken`?PC_BRANCH:PC_PLUS4, retire -> FETCH; others -> WB.
- MEM: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=STORE; on `mem_ready`: STORE retires with `pc_we`=1/PC_PLUS4 -> FETCH; LOAD -> WB.
- WB (1 cycle): `rf_we`=1, `pc_we`=1; `wb_sel`=WB_MEM (LOAD), WB_PC4 (JAL/JALR), else WB_ALU; `pc_sel`=PC_BRANCH (JAL), PC_JALR (JALR), else PC_PLUS4; retire -> FETCH.
- TRAP: all enables 0, `halted`=1; exits only via reset.
- Handshake: `mem_req`, `mem_we`, `mem_addr_sel` held stable until `mem_ready` sampled high; `mem_ready` while `mem_req`=0 ignored.
- Timeout: wait counter clears on entering FETCH/MEM, increments each cycle with `mem_req`&&!`mem_ready`; when it reaches MEM_TIMEOUT with `mem_ready` still low -> TRAP, `bus_err`=1. `mem_ready` on the timeout cycle wins (no error).
- `retired` increments by 1 on each retiring `pc_we`; all-ones wraps to 0.
- `rf_we`, `pc_we`, `ir_we` never asserted in the same cycle as a trap transition.

## Timing
- Outputs combinational from registered state plus `instr`/`mem_ready`/`branch_taken`; no combinational path from `mem_ready` to `mem_req`.
- Zero-wait latencies: BRANCH 3, ALU/LUI/AUIPC/JAL/JALR 4, STORE 4, LOAD 5 cycles; each wait cycle adds 1.
- Retire counter visible the cycle after the retiring edge.
- Reset mid-request drops `mem_req` immediately (async); first post-reset request begins the cycle after deassertion.

## Structure
- `control_defs` package gains `state_e` (FETCH, DECODE, EXEC, MEM, WB, TRAP), `pc_sel_e`, `wb_sel_e`, `alu_op_e`, and RV32I opcode constants.
- Single sub-module `wait_timer`: parametrised (MEM_TIMEOUT) wait counter with clear/enable/expired.

## Test plan
- ADDI (0x00500093), `mem_ready` tied 1 -> `rf_we` in cycle 4, `pc_we` with PC_PLUS4, `retired`=1.
- LW with `mem_ready` low 3 cycles in MEM -> `mem_req`/`mem_addr_sel`=1 held stable 4 cycles, `wb_sel`=WB_MEM, total 8 cycles.
- BEQ with `branch_taken`=1 then 0 -> `pc_sel`=PC_BRANCH then PC_PLUS4 at cycle 3, `rf_we` never set.
- Opcode 7'b0000000 -> TRAP after DECODE, `illegal`=1, `halted`=1, no further `mem_req` until reset.
- MEM_TIMEOUT=4, `mem_ready` stuck 0 in FETCH -> `bus_err`=1 after 4 wait cycles; `mem_ready`=1 exactly on cycle 4 -> no error.
- CNT_W=4, retire 16 instructions -> `retired` wraps 15->0; assert `rst_n` mid-MEM -> outputs 0 same cycle, restart in FETCH.

Source files
------------

// File: rtl/control_defs.sv
// Shared encodings for the multi-cycle RV32I control sequencer: FSM states,
// datapath mux selects, ALU op classes and the RV32I major opcodes.
package control_defs;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JALR   = 2'd2
   } pc_sel_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'd0,
      ALU_FUNCT = 2'd1,
      ALU_CMP   = 2'd2
   } alu_op_e;

   // Instruction class latched in DECODE; OP, OP-IMM and LUI share one path.
   typedef enum logic [2:0] {
      INS_ILLEGAL = 3'd0,
      INS_LOAD    = 3'd1,
      INS_STORE   = 3'd2,
      INS_ALU     = 3'd3,
      INS_AUIPC   = 3'd4,
      INS_JAL     = 3'd5,
      INS_JALR    = 3'd6,
      INS_BRANCH  = 3'd7
   } ins_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   function automatic ins_e classify(input logic [6:0] opcode);
      ins_e cls;
      case (opcode)
         OPC_LOAD:   cls = INS_LOAD;
         OPC_STORE:  cls = INS_STORE;
         OPC_OP:     cls = INS_ALU;
         OPC_OP_IMM: cls = INS_ALU;
         OPC_LUI:    cls = INS_ALU;
         OPC_AUIPC:  cls = INS_AUIPC;
         OPC_JAL:    cls = INS_JAL;
         OPC_JALR:   cls = INS_JALR;
         OPC_BRANCH: cls = INS_BRANCH;
         default:    cls = INS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory request port (valid/ready with wait states).
interface multicycle_controller_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
   modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/wait_timer.sv
// Memory wait-state counter: flags the last permitted wait cycle of a request.
// MEM_TIMEOUT of 0 never expires.
module wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW     = (MEM_TIMEOUT > 32'd1) ? $clog2(MEM_TIMEOUT) : 32'd1;
   localparam int unsigned LAST_I = (MEM_TIMEOUT > 32'd0) ? MEM_TIMEOUT - 32'd1 : 32'd0;
   localparam logic [CW-1:0] LAST = CW'(LAST_I);

   logic [CW-1:0] count_r;

   // Count wait cycles, holding at the last one until the sequencer leaves the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (enable && (count_r != LAST)) begin
         count_r <= count_r + CW'(1);
      end
   end

   // Expired means this is the final wait cycle: no ready now means bus error
   assign expired = (MEM_TIMEOUT != 32'd0) && (count_r == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB over a
// valid/ready memory port, with sticky traps for illegal opcodes and timeouts.
module multicycle_controller
   import control_defs::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   multicycle_controller_if.master mem,
   input  logic [31:0]             instr,
   input  logic                    branch_taken,
   output logic                    ir_we,
   output logic                    pc_we,
   output pc_sel_e                 pc_sel,
   output logic                    rf_we,
   output wb_sel_e                 wb_sel,
   output alu_op_e                 alu_op,
   output logic                    illegal,
   output logic                    bus_err,
   output logic                    halted,
   output logic [CNT_W-1:0]        retired
);

   state_e           state_r;
   state_e           state_nxt_s;
   ins_e             ins_r;
   ins_e             ins_nxt_s;
   logic             run_r;
   logic             illegal_r;
   logic             bus_err_r;
   logic             set_illegal_s;
   logic             set_bus_err_s;
   logic [CNT_W-1:0] retired_r;
   logic             tmr_clear_s;
   logic             tmr_en_s;
   logic             tmr_expired_s;
   logic             unused_instr_s;

   assign unused_instr_s = ^instr[31:7];

   // Only wait states of an outstanding request count toward the timeout
   assign tmr_en_s    = mem.mem_req & ~mem.mem_ready;
   assign tmr_clear_s = (state_nxt_s != state_r);

   wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (tmr_clear_s),
      .enable  (tmr_en_s),
      .expired (tmr_expired_s)
   );

   // State, decoded class, post-reset run gate, sticky traps and retire count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= FETCH;
         ins_r     <= INS_ILLEGAL;
         run_r     <= 1'b0;
         illegal_r <= 1'b0;
         bus_err_r <= 1'b0;
         retired_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         ins_r   <= ins_nxt_s;
         run_r   <= 1'b1;
         if (set_illegal_s) begin
            illegal_r <= 1'b1;
         end
         if (set_bus_err_s) begin
            bus_err_r <= 1'b1;
         end
         if (pc_we) begin
            retired_r <= retired_r + CNT_W'(1);
         end
      end
   end

   // Next-state and control decode; run_r keeps the first request off until
   // the cycle after reset is released
   always_comb begin
      state_nxt_s      = state_r;
      ins_nxt_s        = ins_r;
      set_illegal_s    = 1'b0;
      set_bus_err_s    = 1'b0;
      mem.mem_req      = 1'b0;
      mem.mem_we       = 1'b0;
      mem.mem_addr_sel = 1'b0;
      ir_we            = 1'b0;
      pc_we            = 1'b0;
      pc_sel           = PC_PLUS4;
      rf_we            = 1'b0;
      wb_sel           = WB_ALU;
      alu_op           = ALU_ADD;
      halted           = 1'b0;

      case (state_r)
         FETCH: begin
            if (run_r) begin
               mem.mem_req = 1'b1;
               if (mem.mem_ready) begin
                  ir_we       = 1'b1;
                  state_nxt_s = DECODE;
               end else if (tmr_expired_s) begin
                  set_bus_err_s = 1'b1;
                  state_nxt_s   = TRAP;
               end else begin
                  state_nxt_s = FETCH;
               end
            end else begin
               state_nxt_s = FETCH;
            end
         end

         DECODE: begin
            ins_nxt_s = classify(instr[6:0]);
            if (ins_nxt_s == INS_ILLEGAL) begin
               set_illegal_s = 1'b1;
               state_nxt_s   = TRAP;
            end else begin
               state_nxt_s = EXEC;
            end
         end

         EXEC: begin
            case (ins_r)
               INS_LOAD, INS_STORE: begin
                  alu_op      = ALU_ADD;
                  state_nxt_s = MEM;
               end
               INS_BRANCH: begin
                  alu_op      = ALU_CMP;
                  pc_we       = 1'b1;
                  pc_sel      = branch_taken ? PC_BRANCH : PC_PLUS4;
                  state_nxt_s = FETCH;
               end
               INS_ALU: begin
                  alu_op      = ALU_FUNCT;
                  state_nxt_s = WB;
               end
               INS_AUIPC, INS_JAL, INS_JALR: begin
                  alu_op      = ALU_ADD;
                  state_nxt_s = WB;
               end
               default: begin
                  set_illegal_s = 1'b1;
                  state_nxt_s   = TRAP;
               end
            endcase
         end

         MEM: begin
            mem.mem_req      = 1'b1;
            mem.mem_addr_sel = 1'b1;
            mem.mem_we       = (ins_r == INS_STORE);
            if (mem.mem_ready) begin
               if (ins_r == INS_STORE) begin
                  pc_we       = 1'b1;
                  state_nxt_s = FETCH;
               end else begin
                  state_nxt_s = WB;
               end
            end else if (tmr_expired_s) begin
               set_bus_err_s = 1'b1;
               state_nxt_s   = TRAP;
            end else begin
               state_nxt_s = MEM;
            end
         end

         WB: begin
            rf_we       = 1'b1;
            pc_we       = 1'b1;
            state_nxt_s = FETCH;
            case (ins_r)
               INS_LOAD: begin
                  wb_sel = WB_MEM;
               end
               INS_JAL: begin
                  wb_sel = WB_PC4;
                  pc_sel = PC_BRANCH;
               end
               INS_JALR: begin
                  wb_sel = WB_PC4;
                  pc_sel = PC_JALR;
               end
               default: begin
                  wb_sel = WB_ALU;
                  pc_sel = PC_PLUS4;
               end
            endcase
         end

         TRAP: begin
            halted      = 1'b1;
            state_nxt_s = TRAP;
         end

         default: begin
            state_nxt_s = TRAP;
         end
      endcase
   end

   assign illegal = illegal_r;
   assign bus_err = bus_err_r;
   assign retired = retired_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control vectors with
// hand-computed values, traps, timeout boundary, counter wrap and async reset.
module tb_multicycle_controller;
   import control_defs::*;

   // Control vector: {req, we, asel, ir_we, pc_we, pc_sel[1:0], rf_we, wb_sel[1:0], alu_op[1:0]}
   localparam logic [11:0] IDLE   = 12'h000;
   localparam logic [11:0] F_ACK  = 12'h900;
   localparam logic [11:0] F_WAIT = 12'h800;
   localparam logic [11:0] EX_ADD = 12'h000;
   localparam logic [11:0] EX_FN  = 12'h001;
   localparam logic [11:0] BR_T   = 12'h0A2;
   localparam logic [11:0] BR_N   = 12'h082;
   localparam logic [11:0] M_LD   = 12'hA00;
   localparam logic [11:0] M_ST   = 12'hE80;
   localparam logic [11:0] WB_AL  = 12'h090;
   localparam logic [11:0] WB_LD  = 12'h094;
   localparam logic [11:0] WB_JL  = 12'h0B8;
   localparam logic [11:0] WB_JR  = 12'h0D8;

   localparam logic [31:0] I_ADDI  = 32'h00500093;
   localparam logic [31:0] I_LW    = 32'h0000A103;
   localparam logic [31:0] I_BEQ   = 32'h00000063;
   localparam logic [31:0] I_SW    = 32'h0020A023;
   localparam logic [31:0] I_JAL   = 32'h0000006F;
   localparam logic [31:0] I_JALR  = 32'h00008067;
   localparam logic [31:0] I_LUI   = 32'h123450B7;
   localparam logic [31:0] I_AUIPC = 32'h00000097;
   localparam logic [31:0] I_BAD   = 32'h00000000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'd0;
   logic        branch_taken = 1'b0;
   logic        ir_we, pc_we, rf_we, illegal, bus_err, halted;
   pc_sel_e     pc_sel;
   wb_sel_e     wb_sel;
   alu_op_e     alu_op;
   logic [3:0]  retired;
   logic [11:0] ctl_obs;
   int          n_cmp = 0;
   int          n_err = 0;

   multicycle_controller_if mif();

   multicycle_controller #(
      .MEM_TIMEOUT (4),
      .CNT_W       (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem          (mif),
      .instr        (instr),
      .branch_taken (branch_taken),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .rf_we        (rf_we),
      .wb_sel       (wb_sel),
      .alu_op       (alu_op),
      .illegal      (illegal),
      .bus_err      (bus_err),
      .halted       (halted),
      .retired      (retired)
   );

   always #5 clk = ~clk;

   assign ctl_obs = {mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_we, pc_we,
                     2'(pc_sel), rf_we, 2'(wb_sel), 2'(alu_op)};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive ready, compare controls at the falling edge
   task automatic cyc(input string tag, input logic rdy, input logic [11:0] exp);
      mif.mem_ready = rdy;
      @(negedge clk);
      check_eq(tag, 32'(ctl_obs), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mif.mem_ready = 1'b0;
      branch_taken = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("rst_ctl", 32'(ctl_obs), 32'(IDLE));
      check_eq("rst_flags", 32'({illegal, bus_err, halted}), 32'd0);
      check_eq("rst_retired", 32'(retired), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_idle_first_cycle", 32'(ctl_obs), 32'(IDLE));
      @(posedge clk);
      #1;
   endtask

   // Four-cycle instruction with zero wait states, then the retire count
   task automatic run_short(input string tag, input logic [31:0] word,
                            input logic [11:0] ex_exp, input logic [11:0] wb_exp,
                            input logic [3:0] ret_exp);
      instr = word;
      cyc({tag, "_fetch"}, 1'b1, F_ACK);
      cyc({tag, "_decode"}, 1'b1, IDLE);
      cyc({tag, "_exec"}, 1'b1, ex_exp);
      cyc({tag, "_wb"}, 1'b1, wb_exp);
      check_eq({tag, "_retired"}, 32'(retired), 32'(ret_exp));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      mif.mem_ready = 1'b0;
      do_reset();

      run_short("addi", I_ADDI, EX_FN, WB_AL, 4'd1);
      check_eq("addi_not_halted", 32'(halted), 32'd0);

      // LW: three wait states in MEM, ready on the last permitted cycle
      instr = I_LW;
      cyc("lw_fetch", 1'b1, F_ACK);
      cyc("lw_decode", 1'b1, IDLE);
      cyc("lw_exec", 1'b1, EX_ADD);
      for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, M_LD);
      cyc("lw_mem_ack", 1'b1, M_LD);
      cyc("lw_wb", 1'b1, WB_LD);
      check_eq("lw_retired", 32'(retired), 32'd2);
      check_eq("lw_no_bus_err", 32'(bus_err), 32'd0);

      instr = I_BEQ;
      branch_taken = 1'b1;
      cyc("beq_t_fetch", 1'b1, F_ACK);
      cyc("beq_t_decode", 1'b1, IDLE);
      cyc("beq_t_exec", 1'b1, BR_T);
      check_eq("beq_t_retired", 32'(retired), 32'd3);
      branch_taken = 1'b0;
      cyc("beq_n_fetch", 1'b1, F_ACK);
      cyc("beq_n_decode", 1'b1, IDLE);
      cyc("beq_n_exec", 1'b1, BR_N);
      check_eq("beq_n_retired", 32'(retired), 32'd4);

      instr = I_SW;
      cyc("sw_fetch", 1'b1, F_ACK);
      cyc("sw_decode", 1'b1, IDLE);
      cyc("sw_exec", 1'b1, EX_ADD);
      cyc("sw_mem", 1'b1, M_ST);
      check_eq("sw_retired", 32'(retired), 32'd5);

      run_short("jal", I_JAL, EX_ADD, WB_JL, 4'd6);
      run_short("jalr", I_JALR, EX_ADD, WB_JR, 4'd7);
      run_short("lui", I_LUI, EX_FN, WB_AL, 4'd8);
      run_short("auipc", I_AUIPC, EX_ADD, WB_AL, 4'd9);

      // Counter runs 10..15 then wraps to 0
      for (int i = 0; i < 7; i++) begin
         run_short("addi_wrap", I_ADDI, EX_FN, WB_AL, 4'(10 + i));
      end

      // Fetch ready arrives exactly on the timeout cycle: no error
      instr = I_ADDI;
      for (int i = 0; i < 3; i++) cyc("tmo_edge_wait", 1'b0, F_WAIT);
      cyc("tmo_edge_ack", 1'b1, F_ACK);
      check_eq("tmo_edge_no_err", 32'({bus_err, halted}), 32'd0);
      cyc("tmo_edge_decode", 1'b1, IDLE);
      cyc("tmo_edge_exec", 1'b1, EX_FN);
      cyc("tmo_edge_wb", 1'b1, WB_AL);
      check_eq("tmo_edge_retired", 32'(retired), 32'd1);

      // Illegal opcode traps after DECODE and never requests again
      instr = I_BAD;
      cyc("ill_fetch", 1'b1, F_ACK);
      cyc("ill_decode", 1'b1, IDLE);
      check_eq("ill_flags", 32'({illegal, bus_err, halted}), 32'b101);
      for (int i = 0; i < 3; i++) cyc("ill_trap_quiet", 1'b1, IDLE);
      check_eq("ill_retired_frozen", 32'(retired), 32'd1);
      do_reset();

      // Fetch ready stuck low: bus error after four wait cycles
      for (int i = 0; i < 3; i++) cyc("tmo_wait", 1'b0, F_WAIT);
      check_eq("tmo_not_yet", 32'(bus_err), 32'd0);
      cyc("tmo_last", 1'b0, F_WAIT);
      @(negedge clk);
      check_eq("tmo_flags", 32'({illegal, bus_err, halted}), 32'b011);
      check_eq("tmo_trap_quiet", 32'(ctl_obs), 32'(IDLE));
      @(posedge clk);
      #1;
      do_reset();

      // Async reset in the middle of a load's MEM phase
      run_short("pre_rst_addi", I_ADDI, EX_FN, WB_AL, 4'd1);
      instr = I_LW;
      cyc("mrst_fetch", 1'b1, F_ACK);
      cyc("mrst_decode", 1'b1, IDLE);
      cyc("mrst_exec", 1'b1, EX_ADD);
      mif.mem_ready = 1'b0;
      #2;
      check_eq("mrst_mem_req", 32'(ctl_obs), 32'(M_LD));
      rst_n = 1'b0;
      #1;
      check_eq("mrst_drop", 32'(ctl_obs), 32'(IDLE));
      check_eq("mrst_retired", 32'(retired), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("mrst_idle", 32'(ctl_obs), 32'(IDLE));
      @(posedge clk);
      #1;
      run_short("post_rst_addi", I_ADDI, EX_FN, WB_AL, 4'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
